cmsdk_ahb_copy_master: RTL and testbench

CMSDK_AHB_COPY_MASTER -- requirements
Module: cmsdk_ahb_copy_master

---
 rtl/cmsdk_ahb_copy_master.sv | 149 ++++++++++++++
 tb/tb_cmsdk_ahb_copy_master.sv | 432 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cmsdk_ahb_copy_master.sv
// AHB-Lite copy master: reads a block of 32-bit words from src and writes
// them to dst, one non-overlapped transfer at a time, with error abort.
module cmsdk_ahb_copy_master #(
   parameter int unsigned LEN_W = 10
) (
   input  logic             HCLK,
   input  logic             HRESET,
   input  logic             cmd_valid,
   output logic             cmd_ready,
   input  logic [31:0]      cmd_src,
   input  logic [31:0]      cmd_dst,
   input  logic [LEN_W-1:0] cmd_len,
   output logic             busy,
   output logic             done,
   output logic             err,
   output logic [31:0]      err_addr,
   output logic [31:0]      HADDR,
   output logic [1:0]       HTRANS,
   output logic [2:0]       HSIZE,
   output logic             HWRITE,
   output logic [31:0]      HWDATA,
   output logic [2:0]       HBURST,
   output logic [3:0]       HPROT,
   output logic             HMASTLOCK,
   input  logic [31:0]      HRDATA,
   input  logic             HREADY,
   input  logic             HRESP
);

   typedef enum logic [2:0] {
      IDLE,
      RD_A,
      RD_D,
      WR_A,
      WR_D
   } state_t;

   localparam logic [1:0] TRANS_IDLE   = 2'b00;
   localparam logic [1:0] TRANS_NONSEQ = 2'b10;
   localparam logic [2:0] SIZE_WORD    = 3'b010;

   state_t           state;
   logic [31:0]      src_addr;
   logic [31:0]      dst_addr;
   logic [LEN_W-1:0] remaining;

   assign HBURST    = 3'b000;
   assign HPROT     = 4'b0011;
   assign HMASTLOCK = 1'b0;

   // HWDATA doubles as the word buffer: it is loaded at the end of the read
   // data phase and stays put through the following write address/data phases.
   always_ff @(posedge HCLK) begin
      if (HRESET) begin
         state     <= IDLE;
         src_addr  <= '0;
         dst_addr  <= '0;
         remaining <= '0;
         cmd_ready <= 1'b1;
         busy      <= 1'b0;
         done      <= 1'b0;
         err       <= 1'b0;
         err_addr  <= '0;
         HADDR     <= '0;
         HTRANS    <= TRANS_IDLE;
         HSIZE     <= SIZE_WORD;
         HWRITE    <= 1'b0;
         HWDATA    <= '0;
      end else begin
         done  <= 1'b0;
         err   <= 1'b0;
         HSIZE <= SIZE_WORD;
         case (state)
            IDLE: begin
               // busy still high here means this is the done/err pulse cycle
               if (busy) begin
                  busy      <= 1'b0;
                  cmd_ready <= 1'b1;
               end else if (cmd_valid && cmd_ready) begin
                  cmd_ready <= 1'b0;
                  busy      <= 1'b1;
                  err_addr  <= '0;
                  src_addr  <= {cmd_src[31:2], 2'b00};
                  dst_addr  <= {cmd_dst[31:2], 2'b00};
                  remaining <= cmd_len;
                  if (cmd_len == '0) begin
                     done <= 1'b1;
                  end else begin
                     state  <= RD_A;
                     HTRANS <= TRANS_NONSEQ;
                     HWRITE <= 1'b0;
                     HADDR  <= {cmd_src[31:2], 2'b00};
                  end
               end
            end
            RD_A: begin
               if (HREADY) begin
                  state  <= RD_D;
                  HTRANS <= TRANS_IDLE;
               end
            end
            RD_D: begin
               if (HRESP) begin
                  err_addr <= HADDR;
                  err      <= 1'b1;
                  state    <= IDLE;
               end else if (HREADY) begin
                  HWDATA <= HRDATA;
                  state  <= WR_A;
                  HTRANS <= TRANS_NONSEQ;
                  HWRITE <= 1'b1;
                  HADDR  <= dst_addr;
               end
            end
            WR_A: begin
               if (HREADY) begin
                  state  <= WR_D;
                  HTRANS <= TRANS_IDLE;
               end
            end
            WR_D: begin
               if (HRESP) begin
                  err_addr <= HADDR;
                  err      <= 1'b1;
                  state    <= IDLE;
               end else if (HREADY) begin
                  src_addr  <= src_addr + 32'd4;
                  dst_addr  <= dst_addr + 32'd4;
                  remaining <= remaining - 1'b1;
                  if (remaining == LEN_W'(1)) begin
                     done  <= 1'b1;
                     state <= IDLE;
                  end else begin
                     state  <= RD_A;
                     HTRANS <= TRANS_NONSEQ;
                     HWRITE <= 1'b0;
                     HADDR  <= src_addr + 32'd4;
                  end
               end
            end
            default: begin
               state  <= IDLE;
               HTRANS <= TRANS_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_cmsdk_ahb_copy_master.sv
// Bench for cmsdk_ahb_copy_master: behavioural AHB slave with wait/error
// injection, plus a word-list copy model that predicts bus traffic and timing.
module tb_cmsdk_ahb_copy_master;
   localparam int LEN_W = 10;

   logic             HCLK = 1'b0;
   logic             HRESET = 1'b1;
   logic             cmd_valid = 1'b0;
   logic             cmd_ready;
   logic [31:0]      cmd_src = '0;
   logic [31:0]      cmd_dst = '0;
   logic [LEN_W-1:0] cmd_len = '0;
   logic             busy, done, err;
   logic [31:0]      err_addr, HADDR, HWDATA;
   logic [1:0]       HTRANS;
   logic [2:0]       HSIZE, HBURST;
   logic             HWRITE, HMASTLOCK;
   logic [3:0]       HPROT;
   logic [31:0]      HRDATA = '0;
   logic             HREADY = 1'b1;
   logic             HRESP = 1'b0;

   cmsdk_ahb_copy_master #(.LEN_W(LEN_W)) dut (
      .HCLK(HCLK), .HRESET(HRESET), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
      .cmd_src(cmd_src), .cmd_dst(cmd_dst), .cmd_len(cmd_len), .busy(busy),
      .done(done), .err(err), .err_addr(err_addr), .HADDR(HADDR), .HTRANS(HTRANS),
      .HSIZE(HSIZE), .HWRITE(HWRITE), .HWDATA(HWDATA), .HBURST(HBURST),
      .HPROT(HPROT), .HMASTLOCK(HMASTLOCK), .HRDATA(HRDATA), .HREADY(HREADY),
      .HRESP(HRESP)
   );

   always #5 HCLK = ~HCLK;

   int n_cmp = 0;
   int n_fail = 0;

   // slave memory and the reference model's view of memory
   bit [31:0] smem [bit [31:0]];
   bit [31:0] mmem [bit [31:0]];
   bit [31:0] exp_r[$], exp_wa[$], exp_wd[$];

   // slave configuration
   int        waits = 0;
   bit        err_en = 1'b0;
   bit [31:0] err_at = '0;

   // observations
   int        cyc = 0;
   int        acc_cnt = 0, acc_cyc = 0, done_cnt = 0, done_cyc = 0, err_cnt = 0;
   int        busy_cyc_cnt = 0, both_viol = 0, stab_viol = 0, wa_cnt = 0;
   int        first_ns = -1;
   bit [31:0] rlog[$], wlog_a[$], wlog_d[$];
   bit        oplog[$];

   // slave data-phase tracking
   bit        dp_active = 1'b0, dp_write = 1'b0, dp_err = 1'b0, estage = 1'b0, dp_first = 1'b0;
   bit [31:0] dp_addr = '0, dp_hw = '0;
   int        cnt = 0;

   function automatic bit [31:0] sget(input bit [31:0] a);
      return smem.exists(a) ? smem[a] : 32'h0;
   endfunction

   function automatic bit [31:0] mget(input bit [31:0] a);
      return mmem.exists(a) ? mmem[a] : 32'h0;
   endfunction

   always @(posedge HCLK) begin
      if (HRESET) begin
         dp_active = 1'b0;
         HREADY <= 1'b1;
         HRESP  <= 1'b0;
         HRDATA <= '0;
      end else begin
         if (cmd_valid && cmd_ready) begin acc_cnt++; acc_cyc = cyc; end
         if (busy) busy_cyc_cnt++;
         if (done) begin done_cnt++; done_cyc = cyc; end
         if (err) err_cnt++;
         if (done && err) both_viol++;
         if (HTRANS == 2'b10 && first_ns < 0) first_ns = cyc;
         if (dp_active) begin
            if (HTRANS !== 2'b00 || HADDR !== dp_addr) stab_viol++;
            if (dp_write) begin
               if (dp_first) dp_hw = HWDATA;
               else if (HWDATA !== dp_hw) stab_viol++;
            end
            dp_first = 1'b0;
         end
         if (HREADY) begin
            if (dp_active && dp_write && !dp_err) begin
               smem[dp_addr] = HWDATA;
               wlog_a.push_back(dp_addr);
               wlog_d.push_back(HWDATA);
            end
            if (HTRANS == 2'b10) begin
               dp_active = 1'b1;
               dp_addr   = HADDR;
               dp_write  = HWRITE;
               dp_first  = 1'b1;
               estage    = 1'b0;
               cnt       = waits;
               dp_err    = err_en && !HWRITE && HADDR == err_at;
               oplog.push_back(HWRITE);
               if (!HWRITE) rlog.push_back(HADDR);
               else wa_cnt++;
            end else begin
               dp_active = 1'b0;
            end
         end
         if (!dp_active) begin
            HREADY <= 1'b1; HRESP <= 1'b0;
         end else if (cnt > 0) begin
            HREADY <= 1'b0; HRESP <= 1'b0; cnt--;
         end else if (dp_err && !estage) begin
            HREADY <= 1'b0; HRESP <= 1'b1; estage = 1'b1;
         end else if (dp_err) begin
            HREADY <= 1'b1; HRESP <= 1'b1;
         end else begin
            HREADY <= 1'b1; HRESP <= 1'b0;
            HRDATA <= dp_write ? 32'h0 : sget(dp_addr);
         end
      end
      cyc++;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: time limit reached, got running expected finished");
      $fatal(1);
   end

   task automatic fill(input bit [31:0] s, input int n);
      bit [31:0] a, v;
      for (int i = 0; i < n; i++) begin
         a = {s[31:2], 2'b00} + 32'(4 * i);
         v = $urandom;
         smem[a] = v;
         mmem[a] = v;
      end
   endtask

   // word-by-word copy semantics: nr reads issued, nw words written
   task automatic model_copy(input bit [31:0] s, input bit [31:0] d, input int nr, input int nw);
      bit [31:0] sa, da, v;
      exp_r.delete(); exp_wa.delete(); exp_wd.delete();
      sa = {s[31:2], 2'b00};
      da = {d[31:2], 2'b00};
      for (int i = 0; i < nr; i++) exp_r.push_back(sa + 32'(4 * i));
      for (int i = 0; i < nw; i++) begin
         v = mget(sa + 32'(4 * i));
         mmem[da + 32'(4 * i)] = v;
         exp_wa.push_back(da + 32'(4 * i));
         exp_wd.push_back(v);
      end
   endtask

   task automatic run_cmd(input bit [31:0] s, input bit [31:0] d, input int len, output bit to);
      int a0, d0, e0;
      first_ns = -1;
      rlog.delete(); wlog_a.delete(); wlog_d.delete(); oplog.delete();
      busy_cyc_cnt = 0; wa_cnt = 0;
      a0 = acc_cnt; d0 = done_cnt; e0 = err_cnt; to = 1'b0;
      @(negedge HCLK);
      cmd_src = s; cmd_dst = d; cmd_len = len[LEN_W-1:0]; cmd_valid = 1'b1;
      for (int i = 0; i < 20 && acc_cnt == a0; i++) @(negedge HCLK);
      cmd_valid = 1'b0;
      if (acc_cnt == a0) to = 1'b1;
      for (int i = 0; i < 3000 && done_cnt == d0 && err_cnt == e0; i++) @(negedge HCLK);
      if (done_cnt == d0 && err_cnt == e0) to = 1'b1;
      repeat (3) @(negedge HCLK);
   endtask

   task automatic test_reset();
      HRESET = 1'b1;
      repeat (3) @(negedge HCLK);
      n_cmp++;
      if ({HTRANS, HADDR, HWRITE, HWDATA, HSIZE} !== {2'b00, 32'h0, 1'b0, 32'h0, 3'b010}) begin
         n_fail++;
         $display("FAIL reset_bus: got %h expected %h", {HTRANS, HADDR, HWRITE, HWDATA, HSIZE},
                  {2'b00, 32'h0, 1'b0, 32'h0, 3'b010});
      end
      n_cmp++;
      if ({busy, done, err, err_addr} !== {3'b000, 32'h0}) begin
         n_fail++;
         $display("FAIL reset_status: got %h expected %h", {busy, done, err, err_addr}, {3'b000, 32'h0});
      end
      n_cmp++;
      if ({HBURST, HPROT, HMASTLOCK} !== {3'b000, 4'b0011, 1'b0}) begin
         n_fail++;
         $display("FAIL tie_offs: got %h expected %h", {HBURST, HPROT, HMASTLOCK}, {3'b000, 4'b0011, 1'b0});
      end
      HRESET = 1'b0;
      @(negedge HCLK);
      n_cmp++;
      if (cmd_ready !== 1'b1) begin
         n_fail++;
         $display("FAIL reset_ready: got %b expected 1", cmd_ready);
      end
   endtask

   // same command with a zero-wait and a 2-wait-state slave
   task automatic test_copy();
      bit to;
      int w;
      for (int k = 0; k < 2; k++) begin
         w = 2 * k;
         waits = w;
         stab_viol = 0;
         fill(32'h2000_0000, 4);
         model_copy(32'h2000_0000, 32'h2000_0100, 4, 4);
         run_cmd(32'h2000_0000, 32'h2000_0100, 4, to);
         n_cmp++;
         if (to !== 1'b0) begin n_fail++; $display("FAIL copy_timeout w%0d: got %b expected 0", w, to); end
         n_cmp++;
         if (rlog.size() != exp_r.size() || wlog_a.size() != exp_wa.size()) begin
            n_fail++;
            $display("FAIL copy_counts w%0d: got %0d/%0d expected %0d/%0d", w, rlog.size(), wlog_a.size(),
                     exp_r.size(), exp_wa.size());
         end
         for (int i = 0; i < exp_r.size() && i < rlog.size(); i++) begin
            n_cmp++;
            if (rlog[i] !== exp_r[i]) begin
               n_fail++; $display("FAIL copy_raddr w%0d[%0d]: got %h expected %h", w, i, rlog[i], exp_r[i]);
            end
         end
         for (int i = 0; i < exp_wa.size() && i < wlog_a.size(); i++) begin
            n_cmp++;
            if ({wlog_a[i], wlog_d[i]} !== {exp_wa[i], exp_wd[i]}) begin
               n_fail++;
               $display("FAIL copy_write w%0d[%0d]: got %h expected %h", w, i, {wlog_a[i], wlog_d[i]},
                        {exp_wa[i], exp_wd[i]});
            end
         end
         for (int i = 0; i < oplog.size(); i++) begin
            n_cmp++;
            if (oplog[i] !== 1'(i % 2)) begin
               n_fail++; $display("FAIL copy_interleave w%0d[%0d]: got %b expected %b", w, i, oplog[i], 1'(i % 2));
            end
         end
         n_cmp++;
         if (done_cyc - first_ns != 4 * (4 + 2 * w)) begin
            n_fail++;
            $display("FAIL copy_latency w%0d: got %0d expected %0d", w, done_cyc - first_ns, 4 * (4 + 2 * w));
         end
         n_cmp++;
         if (stab_viol != 0) begin n_fail++; $display("FAIL copy_stable w%0d: got %0d expected 0", w, stab_viol); end
      end
      waits = 0;
   endtask

   task automatic test_zero_len();
      bit to;
      run_cmd(32'h2000_0000, 32'h2000_0100, 0, to);
      n_cmp++;
      if (to !== 1'b0) begin n_fail++; $display("FAIL zero_timeout: got %b expected 0", to); end
      n_cmp++;
      if (first_ns != -1) begin n_fail++; $display("FAIL zero_nonseq: got %0d expected -1", first_ns); end
      n_cmp++;
      if (done_cyc - acc_cyc != 1) begin
         n_fail++; $display("FAIL zero_done_delay: got %0d expected 1", done_cyc - acc_cyc);
      end
      n_cmp++;
      if (busy_cyc_cnt != 1) begin n_fail++; $display("FAIL zero_busy_cycles: got %0d expected 1", busy_cyc_cnt); end
   endtask

   task automatic test_error();
      bit to;
      int d0, e0;
      d0 = done_cnt; e0 = err_cnt; both_viol = 0;
      err_en = 1'b1; err_at = 32'h2000_0008;
      fill(32'h2000_0000, 4);
      model_copy(32'h2000_0000, 32'h2000_0100, 3, 2);
      run_cmd(32'h2000_0000, 32'h2000_0100, 4, to);
      err_en = 1'b0;
      n_cmp++;
      if (to !== 1'b0) begin n_fail++; $display("FAIL err_timeout: got %b expected 0", to); end
      n_cmp++;
      if ({err_cnt - e0, done_cnt - d0} != {32'd1, 32'd0}) begin
         n_fail++; $display("FAIL err_pulses: got err %0d done %0d expected err 1 done 0", err_cnt - e0, done_cnt - d0);
      end
      n_cmp++;
      if (err_addr !== 32'h2000_0008) begin
         n_fail++; $display("FAIL err_addr: got %h expected 20000008", err_addr);
      end
      n_cmp++;
      if (rlog.size() != 3 || wlog_a.size() != 2) begin
         n_fail++; $display("FAIL err_traffic: got %0d reads %0d writes expected 3 reads 2 writes", rlog.size(), wlog_a.size());
      end
      for (int i = 0; i < 2 && i < wlog_a.size(); i++) begin
         n_cmp++;
         if ({wlog_a[i], wlog_d[i]} !== {exp_wa[i], exp_wd[i]}) begin
            n_fail++;
            $display("FAIL err_write[%0d]: got %h expected %h", i, {wlog_a[i], wlog_d[i]}, {exp_wa[i], exp_wd[i]});
         end
      end
      n_cmp++;
      if (both_viol != 0) begin n_fail++; $display("FAIL done_err_overlap: got %0d expected 0", both_viol); end
   endtask

   task automatic test_wrap();
      bit to;
      bit [31:0] want [3];
      want[0] = 32'hFFFF_FFF8; want[1] = 32'hFFFF_FFFC; want[2] = 32'h0000_0000;
      fill(32'hFFFF_FFF8, 2);
      fill(32'h0000_0000, 1);
      model_copy(32'hFFFF_FFF8, 32'h3000_0000, 3, 3);
      run_cmd(32'hFFFF_FFF8, 32'h3000_0000, 3, to);
      n_cmp++;
      if (to !== 1'b0 || rlog.size() != 3) begin
         n_fail++; $display("FAIL wrap_reads: got %0d reads timeout %b expected 3 reads timeout 0", rlog.size(), to);
      end
      for (int i = 0; i < 3 && i < rlog.size(); i++) begin
         n_cmp++;
         if (rlog[i] !== want[i]) begin
            n_fail++; $display("FAIL wrap_raddr[%0d]: got %h expected %h", i, rlog[i], want[i]);
         end
      end
      for (int i = 0; i < exp_wd.size() && i < wlog_d.size(); i++) begin
         n_cmp++;
         if (wlog_d[i] !== exp_wd[i]) begin
            n_fail++; $display("FAIL wrap_wdata[%0d]: got %h expected %h", i, wlog_d[i], exp_wd[i]);
         end
      end
   endtask

   task automatic test_reset_midway();
      bit to, found;
      int d0, e0;
      fill(32'h2000_0040, 5);
      rlog.delete(); wlog_a.delete(); wlog_d.delete(); oplog.delete(); wa_cnt = 0;
      @(negedge HCLK);
      cmd_src = 32'h2000_0040; cmd_dst = 32'h2000_0200; cmd_len = 10'd5; cmd_valid = 1'b1;
      @(negedge HCLK);
      cmd_valid = 1'b0;
      found = 1'b0;
      for (int i = 0; i < 200 && !found; i++) begin
         if (HTRANS == 2'b10 && HWRITE && wa_cnt == 1) found = 1'b1;
         else @(negedge HCLK);
      end
      n_cmp++;
      if (!found) begin n_fail++; $display("FAIL midrst_reach_wr_a: got 0 expected 1"); end
      d0 = done_cnt; e0 = err_cnt;
      HRESET = 1'b1;
      @(posedge HCLK); #1;
      n_cmp++;
      if ({HTRANS, busy} !== 3'b000) begin
         n_fail++; $display("FAIL midrst_abort: got htrans/busy %b expected 000", {HTRANS, busy});
      end
      @(negedge HCLK);
      HRESET = 1'b0;
      repeat (5) @(negedge HCLK);
      n_cmp++;
      if ({done_cnt - d0, err_cnt - e0, wlog_a.size()} != {32'd0, 32'd0, 32'd1}) begin
         n_fail++;
         $display("FAIL midrst_no_pulse: got done %0d err %0d writes %0d expected 0 0 1",
                  done_cnt - d0, err_cnt - e0, wlog_a.size());
      end
      // first word was written before the reset, keep the model in step
      mmem[32'h2000_0200] = mget(32'h2000_0040);
      fill(32'h2000_0080, 3);
      model_copy(32'h2000_0080, 32'h2000_0300, 3, 3);
      run_cmd(32'h2000_0080, 32'h2000_0300, 3, to);
      n_cmp++;
      if (to !== 1'b0 || wlog_a.size() != 3) begin
         n_fail++; $display("FAIL midrst_recover: got %0d writes timeout %b expected 3 writes timeout 0", wlog_a.size(), to);
      end
      for (int i = 0; i < 3 && i < wlog_a.size(); i++) begin
         n_cmp++;
         if ({wlog_a[i], wlog_d[i]} !== {exp_wa[i], exp_wd[i]}) begin
            n_fail++;
            $display("FAIL midrst_write[%0d]: got %h expected %h", i, {wlog_a[i], wlog_d[i]}, {exp_wa[i], exp_wd[i]});
         end
      end
   endtask

   task automatic test_random();
      bit to;
      bit [31:0] s, d;
      int len, w;
      for (int k = 0; k < 8; k++) begin
         w = $urandom_range(0, 3);
         len = $urandom_range(1, 6);
         s = $urandom;
         d = ($urandom_range(0, 1) == 1) ? s + 32'(4 * $urandom_range(1, 3)) : 32'($urandom);
         waits = w;
         stab_viol = 0;
         fill(s, len);
         model_copy(s, d, len, len);
         run_cmd(s, d, len, to);
         n_cmp++;
         if (to !== 1'b0 || rlog.size() != len || wlog_a.size() != len) begin
            n_fail++;
            $display("FAIL rand%0d_counts: got r%0d w%0d to%b expected r%0d w%0d to0", k, rlog.size(),
                     wlog_a.size(), to, len, len);
         end
         for (int i = 0; i < len && i < rlog.size(); i++) begin
            n_cmp++;
            if (rlog[i] !== exp_r[i]) begin
               n_fail++; $display("FAIL rand%0d_raddr[%0d]: got %h expected %h", k, i, rlog[i], exp_r[i]);
            end
         end
         for (int i = 0; i < len && i < wlog_a.size(); i++) begin
            n_cmp++;
            if ({wlog_a[i], wlog_d[i]} !== {exp_wa[i], exp_wd[i]}) begin
               n_fail++;
               $display("FAIL rand%0d_write[%0d]: got %h expected %h", k, i, {wlog_a[i], wlog_d[i]},
                        {exp_wa[i], exp_wd[i]});
            end
         end
         n_cmp++;
         if (done_cyc - first_ns != len * (4 + 2 * w) || stab_viol != 0) begin
            n_fail++;
            $display("FAIL rand%0d_timing: got %0d cycles %0d unstable expected %0d cycles 0 unstable", k,
                     done_cyc - first_ns, stab_viol, len * (4 + 2 * w));
         end
      end
      waits = 0;
   endtask

   initial begin
      test_reset();
      test_copy();
      test_zero_len();
      test_error();
      test_wrap();
      test_reset_midway();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
